// File: rtl/instr_prefetch_buffer_if.sv
// Instruction prefetch bus: core-side fetch handshake plus memory-side fetch handshake.
// The slave modport is the prefetcher's view; master is the environment (core + memory).
interface instr_prefetch_buffer_if;
    logic        core_flush_i;
    logic        core_req_i;
    logic [31:0] core_addr_i;
    logic        core_rsp_o;
    logic [31:0] core_data_o;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_rsp_i;
    logic [31:0] mem_data_i;

    modport slave (
        input  core_flush_i, core_req_i, core_addr_i, mem_rsp_i, mem_data_i,
        output core_rsp_o, core_data_o, mem_req_o, mem_addr_o
    );

    modport master (
        output core_flush_i, core_req_i, core_addr_i, mem_rsp_i, mem_data_i,
        input  core_rsp_o, core_data_o, mem_req_o, mem_addr_o
    );
endinterface

// File: rtl/instr_prefetch_buffer.sv
// Sequential instruction prefetcher: runs ahead of the core filling a DEPTH-entry FIFO,
// serves matching core requests from the head and redirects the stream on any mismatch.
module instr_prefetch_buffer #(
    parameter logic [31:0] BOOT_ADDRESS = 32'h0000_0000,
    parameter int          DEPTH        = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    instr_prefetch_buffer_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] PTR_ONE = 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_DISCARD
    } state_t;

    state_t      r_state;
    logic [31:0] r_next_addr;
    logic        r_core_rsp;
    logic [31:0] r_core_data;
    logic        r_mem_req;
    logic [31:0] r_mem_addr;
    logic [PW:0] r_wr_ptr;
    logic [PW:0] r_rd_ptr;
    logic [29:0] r_fifo_addr [DEPTH];
    logic [31:0] r_fifo_data [DEPTH];

    logic        w_empty;
    logic        w_full;
    logic [29:0] w_head_addr;
    logic [31:0] w_head_data;
    logic [31:0] w_expected_addr;
    logic        w_hit;
    logic        w_redirect;
    logic        w_clear;
    logic        w_pop;
    logic        w_push;
    logic        w_issue;
    logic        w_unused_bits;

    assign bus.core_rsp_o  = r_core_rsp;
    assign bus.core_data_o = r_core_data;
    assign bus.mem_req_o   = r_mem_req;
    assign bus.mem_addr_o  = r_mem_addr;

    // The core fetch stage selects halfwords itself; only the word index matters here.
    assign w_unused_bits = &{1'b0, bus.core_addr_i[1:0]};

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_empty     = (r_wr_ptr == r_rd_ptr);
        w_full      = (r_wr_ptr[PW] != r_rd_ptr[PW]) && (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]);
        w_head_addr = r_fifo_addr[r_rd_ptr[PW-1:0]];
        w_head_data = r_fifo_data[r_rd_ptr[PW-1:0]];

        w_expected_addr = r_next_addr;
        if (!w_empty) begin
            w_expected_addr = {w_head_addr, 2'b00};
        end else if (r_state == S_FETCH) begin
            w_expected_addr = r_mem_addr;
        end

        // Compare only while no response is showing: the core's address is stale in that cycle.
        w_hit      = bus.core_req_i && !w_empty && !r_core_rsp
                     && (w_head_addr == bus.core_addr_i[31:2]);
        w_redirect = bus.core_req_i && !r_core_rsp
                     && (w_expected_addr[31:2] != bus.core_addr_i[31:2]);
        w_clear    = w_redirect || bus.core_flush_i;
        w_pop      = w_hit && !bus.core_flush_i;
        w_push     = (r_state == S_FETCH) && bus.mem_rsp_i && !w_clear;
        w_issue    = (r_state == S_IDLE) && !w_full && !w_clear;
    end

    // NOTE: the FIFO storage has no reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_addr[r_wr_ptr[PW-1:0]] <= r_mem_addr[31:2];
            r_fifo_data[r_wr_ptr[PW-1:0]] <= bus.mem_data_i;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_next_addr <= BOOT_ADDRESS;
            r_core_rsp  <= 1'b0;
            r_core_data <= 32'h0;
            r_mem_req   <= 1'b0;
            r_mem_addr  <= 32'h0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
        end else begin
            r_core_rsp <= w_pop;
            if (w_pop) begin
                r_core_data <= w_head_data;
            end

            if (w_clear) begin
                r_rd_ptr <= r_wr_ptr;
            end else begin
                if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
                if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end

            // A flush without a request keeps next_addr; the following request will redirect.
            if (w_clear && bus.core_req_i) begin
                r_next_addr <= {bus.core_addr_i[31:2], 2'b00};
            end else if (w_issue) begin
                r_next_addr <= r_next_addr + 32'd4;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_issue) begin
                        r_mem_req  <= 1'b1;
                        r_mem_addr <= r_next_addr;
                        r_state    <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    // A response landing together with a redirect completes the fetch but is dropped.
                    if (bus.mem_rsp_i) begin
                        r_mem_req <= 1'b0;
                        r_state   <= S_IDLE;
                    end else if (w_clear) begin
                        r_state <= S_DISCARD;
                    end
                end
                S_DISCARD: begin
                    if (bus.mem_rsp_i) begin
                        r_mem_req <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end
                default: begin
                    r_mem_req <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end
endmodule
